regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width in bits (8..64).
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count (power of two, 4..64).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, giving the XLEN-bit value loaded into registers 1..NREG-1 on reset.
REQ-004 The block SHALL derive localparam AW = log2(NREG) as the address width.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have ports rs1_addr and rs2_addr, input, AW bits each: read-port addresses.
REQ-008 The block SHALL have ports rs1_data and rs2_data, output, XLEN bits each: read-port data.
REQ-009 The block SHALL have ports rs1_busy and rs2_busy, output, 1 bit each: the addressed register has an outstanding write.
REQ-010 The block SHALL have port issue_en, input, 1 bit: an instruction targeting issue_rd issues this cycle.
REQ-011 The block SHALL have port issue_rd, input, AW bits: destination of the issuing instruction.
REQ-012 The block SHALL have ports wb_en (input, 1 bit), wb_addr (input, AW bits) and wb_data (input, XLEN bits): the writeback port.
REQ-013 The block SHALL have port flush, input, 1 bit: discard all outstanding writes.
REQ-014 The block SHALL have port pending_cnt, output, AW+1 bits: count of busy registers.

Function
REQ-015 Register 0 SHALL read as 0 at all times; writes and issues to address 0 SHALL be ignored, and address 0 SHALL never be busy.
REQ-016 Reads SHALL be combinational: rsN_data = mem[rsN_addr], subject to REQ-015 and REQ-017.
REQ-017 Write-through bypass: when wb_en=1 and wb_addr=rsN_addr≠0, rsN_data SHALL equal wb_data in the same cycle.
REQ-018 On a rising clk edge with wb_en=1 and wb_addr≠0, mem[wb_addr] SHALL take the value wb_data.
REQ-019 The per-register busy bit SHALL be set on a clk edge with issue_en=1 and issue_rd≠0, and cleared on a clk edge with wb_en=1 to that address.
REQ-020 When issue and writeback target the same address on the same edge, the set SHALL win (a new producer is in flight) and the data write SHALL still occur.
REQ-021 An issue to an already-busy register SHALL leave it busy (one bit per register, no producer count).
REQ-022 rsN_busy SHALL equal busy[rsN_addr] AND NOT (wb_en AND wb_addr=rsN_addr); a bypassed operand SHALL be reported not busy.
REQ-023 rsN_busy SHALL NOT reflect an issue in the same cycle; the bit is visible from the following cycle.
REQ-024 flush=1 at a clk edge SHALL clear all busy bits; an issue on the same edge SHALL then set its bit (issue wins over flush), and a writeback on the same edge SHALL still update data.
REQ-025 A writeback to a non-busy register SHALL update data and leave the busy bit clear.
REQ-026 pending_cnt SHALL be registered and equal the population count of the busy vector after each edge (0..NREG-1).

Reset
REQ-027 While reset=1, registers 1..NREG-1 SHALL hold RESET_VAL, all busy bits and pending_cnt SHALL be 0, and the block SHALL ignore issue, writeback and flush.
REQ-028 Reset SHALL take effect immediately without waiting for clk, including mid-operation with busy bits outstanding.
REQ-029 After reset deasserts, the first clk edge SHALL perform normal writes and issues.

Verification
REQ-030 Reset with RESET_VAL=0x5; read addresses 0 and 7 -> rs1_data=0, rs2_data=0x5, pending_cnt=0.
REQ-031 Drive wb_en=1, wb_addr=3, wb_data=0xDEADBEEF, rs1_addr=3 -> rs1_data=0xDEADBEEF in the same cycle (bypass); after the edge with wb_en=0 -> still 0xDEADBEEF.
REQ-032 Issue rd=5, then rs2_addr=5 in the next cycle -> rs2_busy=1 and pending_cnt=1; in the writeback cycle to 5 -> rs2_busy=0 with the bypassed data; afterwards pending_cnt=0.
REQ-033 Issue rd=9 and writeback addr 9 on the same edge -> busy[9] stays 1 and mem[9] is updated.
REQ-034 Issue 4, 6 and 8; then flush together with issue 10 -> pending_cnt goes 3 then 1, and only register 10 is busy.
REQ-035 Issue 12, then assert reset mid-cycle -> pending_cnt=0 and mem[12]=RESET_VAL before the next edge; a write or issue to address 0 -> reads 0 and is never busy.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: read ports, issue port, writeback port, flush and busy count.
// master drives requests (core side), slave is the register file.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic [AW:0]     pending_cnt;

  modport master (
    output rs1_addr, rs2_addr, issue_en, issue_rd, wb_en, wb_addr, wb_data, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, pending_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_en, issue_rd, wb_en, wb_addr, wb_data, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, pending_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-through bypass and a per-register
// busy scoreboard tracking outstanding writes; register 0 is hardwired to zero.
module regfile_scoreboard #(
  parameter int              XLEN      = 32,
  parameter int              NREG      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pending_cnt_q, pending_cnt_d;

  logic wb_live;
  logic iss_live;
  logic byp1, byp2;

  assign wb_live  = bus.wb_en && (bus.wb_addr != '0);
  assign iss_live = bus.issue_en && (bus.issue_rd != '0);
  assign byp1     = wb_live && (bus.wb_addr == bus.rs1_addr);
  assign byp2     = wb_live && (bus.wb_addr == bus.rs2_addr);

  // Ordering encodes priority: flush, then writeback clear, then issue set.
  always_comb begin
    busy_d = bus.flush ? '0 : busy_q;
    if (wb_live)  busy_d[bus.wb_addr]  = 1'b0;
    if (iss_live) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_cnt_d = '0;
    for (int i = 0; i < NREG; i++)
      pending_cnt_d = pending_cnt_d + (AW+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        mem_q[i] <= (i == 0) ? '0 : RESET_VAL;
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      if (wb_live) mem_q[bus.wb_addr] <= bus.wb_data;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  always_comb begin
    bus.rs1_data = byp1 ? bus.wb_data : mem_q[bus.rs1_addr];
    bus.rs2_data = byp2 ? bus.wb_data : mem_q[bus.rs2_addr];
    if (bus.rs1_addr == '0) bus.rs1_data = '0;
    if (bus.rs2_addr == '0) bus.rs2_data = '0;
  end

  // A bypassed operand is already available, so it is not reported busy.
  assign bus.rs1_busy    = busy_q[bus.rs1_addr] && !byp1;
  assign bus.rs2_busy    = busy_q[bus.rs2_addr] && !byp2;
  assign bus.pending_cnt = pending_cnt_q;
endmodule
